dp_bram_pipe: RTL

Parametrised true dual-port block RAM, the next generation of the accelerator wrapper's 72x512 buffer. It generalises width and depth, and adds per-port byte-lane write enables, a selectable read latency of 1 or 2 cycles, and a selectable same-port write mode. It also adds deterministic cross-port collision resolution with a collision pulse and counter. It sits between the host DMA side (port A) and the accelerator datapath (port B) as a shared operand/result buffer.

---
 rtl/dp_bram_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dp_bram_pipe.sv
// True dual-port RAM with byte-lane writes, 1/2-cycle read latency, selectable write mode.
// Cross-port collisions resolve deterministically (port A owns contested lanes) and are counted.
module dp_bram_pipe #(
  parameter  int WIDTH        = 72,
  parameter  int DEPTH        = 512,
  parameter  int ADDR_W       = 9,
  parameter  int LANE_W       = 8,
  parameter  int READ_LATENCY = 1,
  parameter  int WRITE_MODE   = 0,
  parameter  int CNT_W        = 16,
  localparam int NLANES       = WIDTH / LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic [NLANES-1:0] we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              en_b,
  input  logic [NLANES-1:0] we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b,
  output logic              coll,
  output logic [CNT_W-1:0]  coll_cnt,
  output logic              addr_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [1:0]                  acc, wr, inr, rv_nxt;
  logic [1:0][ADDR_W-1:0]      addr;
  logic [1:0][NLANES-1:0]      we;
  logic [1:0][WIDTH-1:0]       wd, old_w, fin_w, rd_nxt;
  logic                        hit;
  logic [1:0]                  s1_vld, out_vld;
  logic [1:0][WIDTH-1:0]       s1_dat, out_dat;

  // Requests presented while reset is asserted are dropped entirely.
  assign acc  = {en_b, en_a} & {2{rst_n}};
  assign addr = {addr_b, addr_a};
  assign we   = {we_b, we_a};
  assign wd   = {wdata_b, wdata_a};
  assign hit  = acc[0] & acc[1] & (addr[0] == addr[1]) & (wr[0] | wr[1]);

  always_comb begin
    wr     = '0;
    inr    = '0;
    old_w  = '0;
    fin_w  = '0;
    rv_nxt = '0;
    rd_nxt = '0;
    for (int p = 0; p < 2; p++) begin
      wr[p]    = |we[p];
      inr[p]   = {1'b0, addr[p]} < (ADDR_W + 1)'(DEPTH);
      old_w[p] = inr[p] ? mem[addr[p][IW-1:0]] : '0;
      fin_w[p] = old_w[p];
      // On a collision both ports see the same merged word: A lanes first, then B.
      for (int i = 0; i < NLANES; i++) begin
        if (hit && we[0][i])
          fin_w[p][i*LANE_W +: LANE_W] = wd[0][i*LANE_W +: LANE_W];
        else if (hit && we[1][i])
          fin_w[p][i*LANE_W +: LANE_W] = wd[1][i*LANE_W +: LANE_W];
        else if (!hit && we[p][i])
          fin_w[p][i*LANE_W +: LANE_W] = wd[p][i*LANE_W +: LANE_W];
      end
      if (!inr[p])
        fin_w[p] = '0;
      rv_nxt[p] = acc[p] && !(wr[p] && WRITE_MODE == 2);
      rd_nxt[p] = (wr[p] && WRITE_MODE == 1) ? fin_w[p] : old_w[p];
    end
  end

  // Port A is written last so its lanes override B's on a shared address.
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (acc[p] && inr[p]) begin
        for (int i = 0; i < NLANES; i++) begin
          if (we[p][i])
            mem[addr[p][IW-1:0]][i*LANE_W +: LANE_W] <= wd[p][i*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld   <= '0;
      s1_dat   <= '0;
      coll     <= 1'b0;
      coll_cnt <= '0;
      addr_err <= 1'b0;
    end else begin
      s1_vld <= rv_nxt;
      for (int p = 0; p < 2; p++) begin
        if (rv_nxt[p])
          s1_dat[p] <= rd_nxt[p];
      end
      coll <= hit;
      if (hit && !(&coll_cnt))
        coll_cnt <= coll_cnt + 1'b1;
      if (|(acc & ~inr))
        addr_err <= 1'b1;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [1:0]            s2_vld;
      logic [1:0][WIDTH-1:0] s2_dat;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_vld <= '0;
          s2_dat <= '0;
        end else begin
          s2_vld <= s1_vld;
          for (int p = 0; p < 2; p++) begin
            if (s1_vld[p])
              s2_dat[p] <= s1_dat[p];
          end
        end
      end
      assign out_vld = s2_vld;
      assign out_dat = s2_dat;
    end else begin : g_lat1
      assign out_vld = s1_vld;
      assign out_dat = s1_dat;
    end
  endgenerate

  assign rvalid_a = out_vld[0];
  assign rvalid_b = out_vld[1];
  assign rdata_a  = out_dat[0];
  assign rdata_b  = out_dat[1];

endmodule
